x68k_ldr_ctrl: RTL and testbench
================================

Name: x68k_ldr_ctrl

Overview:
Sequences the HPS ioctl byte download stream into the X68K_top loader port. It gates the download by index and packs big-endian byte pairs into 16-bit words with byte enables. Words are buffered in a small FIFO and issued with a req/ack handshake. The block back-pressures the HPS via ioctl_wait and generates ldr_aen/ldr_done. It replaces the ad-hoc ldr_wr/ldr_done glue between hps_io and X68K_top in emu.

Parameters:
ADDR_W, 20, loader byte-address width; ldr_addr is word-aligned (bit 0 always 0).
FIFO_DEPTH, 4, word FIFO entries; power of 2, minimum 2.
LDR_INDEX, 0, ioctl_index value accepted as a loader download; other indices are ignored entirely.

Ports:
clk_sys  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
ioctl_download  in  1  HPS download active.
ioctl_index  in  8  download target index.
ioctl_wr  in  1  one-cycle byte strobe.
ioctl_addr  in  25  byte address of ioctl_dout.
ioctl_dout  in  8  download byte.
ioctl_wait  out  1  back-pressure to hps_io.
ldr_aen  out  1  loader owns memory; high from accepted download start until FIFO drained after download end.
ldr_addr  out  ADDR_W  word-aligned byte address of the head word.
ldr_wdat  out  16  head word; even byte in [15:8], odd byte in [7:0].
ldr_be  out  2  byte enables {even, odd}.
ldr_wr  out  1  write request; level signal.
ldr_ack  in  1  write accepted.
ldr_done  out  1  sticky completion flag.
ldr_ovf  out  1  sticky flag: a byte was dropped because its address was out of range.

Behaviour:
- Reset (async): state IDLE; FIFO empty; partial-word register empty; all outputs 0.
- States:
  - IDLE -> ACTIVE on rising edge of ioctl_download with ioctl_index==LDR_INDEX. Entering ACTIVE clears ldr_done and ldr_ovf and sets ldr_aen.
  - ACTIVE -> FLUSH on falling edge of ioctl_download.
  - FLUSH -> DONE when the partial register is empty, the FIFO is empty and no transfer is pending.
  - DONE: ldr_aen=0, ldr_done=1.
  - DONE -> ACTIVE on a new matching download start, which clears both flags.
  - A non-matching download never leaves IDLE or DONE and produces no outputs.
- Byte capture, in ACTIVE on ioctl_wr:
  - If ioctl_addr[24:ADDR_W] != 0, drop the byte and set ldr_ovf.
  - Otherwise let waddr = {ioctl_addr[ADDR_W-1:1],0}.
  - If a partial word is pending and its waddr differs, push the partial (single be bit set) to the FIFO, then start a new partial with this byte.
  - If this byte completes the partial (same waddr, opposite lane not yet set), merge it and push with be=2'b11.
  - If the same lane is rewritten, the later byte overwrites the earlier one; no push.
  - Even address -> [15:8]/be[1]; odd -> [7:0]/be[0].
- Flush: in FLUSH, a non-empty partial is pushed as soon as the FIFO has space.
- FIFO: first-word-fall-through. ldr_wr = FIFO non-empty.
  - ldr_addr, ldr_wdat and ldr_be are driven from the head entry and held stable while ldr_wr=1 and ldr_ack=0.
  - Pop occurs on any cycle with ldr_wr & ldr_ack; the next entry is presented the following cycle, so back-to-back acks give 1 word/cycle.
  - ldr_ack while ldr_wr=0 is ignored.
  - Push and pop in the same cycle leave the count unchanged.
- Latency: a completed word reaches ldr_wr 1 cycle after the completing ioctl_wr, when the FIFO was empty.
- ioctl_wait = 1 when FIFO count >= FIFO_DEPTH-1 (registered). This guarantees one in-flight byte always fits. A push into a full FIFO must not occur; assert it in simulation.
- Reset mid-transfer drops all buffered data immediately. ldr_wr falls asynchronously, and no ack is required afterwards.

Test Plan:
- Matching download of bytes 0x11,0x22,0x33,0x44 at addr 0..3, ack every cycle -> two writes: (0x00000, 0x1122, be=11) and (0x00002, 0x3344, be=11). ldr_done=1 within 3 cycles of download falling. ldr_aen then 0.
- Odd length, 3 bytes 0xAA,0xBB,0xCC at addr 0x100..0x102 -> writes (0x100, 0xAABB, 11) and (0x102, 0xCC00, be=10). The second write is issued only after download falls.
- Discontiguous bytes: addr 5 = 0x77, then addr 8 = 0x88 -> (0x004, 0x0077, be=01) is pushed when the addr-8 byte arrives.
- Hold ldr_ack=0 while streaming 12 bytes -> ioctl_wait rises after FIFO count reaches 3. There is no data loss, and ldr_addr/ldr_wdat stay stable. Release ack -> all 6 words are delivered in order.
- Download with ioctl_index=2 -> no ldr_wr, ldr_aen=0, ldr_done unchanged. Byte at ioctl_addr=0x100000 with ADDR_W=20 -> dropped, ldr_ovf=1.
- Assert reset for 1 cycle with 2 words queued and ldr_wr=1 -> ldr_wr, ldr_aen and ldr_done are 0 immediately. A new matching download then operates normally.

Source files
------------

// File: rtl/x68k_ldr_ctrl.sv
// x68k_ldr_ctrl: turns the HPS ioctl byte download stream into 16-bit
// loader writes for X68K_top. Bytes are packed big-endian into words with
// byte enables, queued in a small first-word-fall-through FIFO, and issued
// on a level req (ldr_wr) / ack (ldr_ack) handshake. ioctl_wait throttles
// the HPS so that the FIFO never overflows.
module x68k_ldr_ctrl #(
    parameter int         ADDR_W     = 20,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] LDR_INDEX  = 8'd0
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic              ldr_aen,
    output logic [ADDR_W-1:0] ldr_addr,
    output logic [15:0]       ldr_wdat,
    output logic [1:0]        ldr_be,
    output logic              ldr_wr,
    input  logic              ldr_ack,
    output logic              ldr_done,
    output logic              ldr_ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_FLUSH, ST_DONE} state_t;

    state_t state_reg, state_next;
    logic   dl_prev_reg;
    logic   ovf_reg;
    logic   wait_reg;

    // Partial word being assembled; part_be_reg == 0 means empty.
    logic [1:0]        part_be_reg,   part_be_next;
    logic [ADDR_W-1:0] part_addr_reg, part_addr_next;
    logic [15:0]       part_data_reg, part_data_next;

    // Word FIFO storage and bookkeeping.
    logic [ADDR_W-1:0] fifo_addr_mem [FIFO_DEPTH];
    logic [15:0]       fifo_data_mem [FIFO_DEPTH];
    logic [1:0]        fifo_be_mem   [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg, count_next;

    logic              fifo_empty, fifo_full, fifo_push, fifo_pop;
    logic [ADDR_W-1:0] push_addr;
    logic [15:0]       push_data;
    logic [1:0]        push_be;
    logic              ovf_set;

    logic              dl_rise, dl_match, enter_active;
    logic              byte_cap, byte_oor, byte_odd;
    logic [ADDR_W-1:0] byte_waddr;
    logic [1:0]        byte_be;
    logic [15:0]       byte_lane_data;

    assign dl_rise      = ioctl_download && !dl_prev_reg;
    assign dl_match     = dl_rise && (ioctl_index == LDR_INDEX);
    assign enter_active = (state_reg != ST_ACTIVE) && (state_next == ST_ACTIVE);

    assign byte_cap       = (state_reg == ST_ACTIVE) && ioctl_wr;
    assign byte_oor       = |ioctl_addr[24:ADDR_W];
    assign byte_odd       = ioctl_addr[0];
    assign byte_waddr     = {ioctl_addr[ADDR_W-1:1], 1'b0};
    assign byte_be        = byte_odd ? 2'b01 : 2'b10;
    assign byte_lane_data = byte_odd ? {8'h00, ioctl_dout} : {ioctl_dout, 8'h00};

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign fifo_pop   = !fifo_empty && ldr_ack;

    // FSM state register; also remembers the previous download level for edge detection.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            dl_prev_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            dl_prev_reg <= ioctl_download;
        end
    end

    // FSM next-state: only a matching download start leaves IDLE/DONE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (dl_match) state_next = ST_ACTIVE;
            ST_ACTIVE: if (!ioctl_download) state_next = ST_FLUSH;
            ST_FLUSH:  if ((part_be_reg == 2'b00) && fifo_empty) state_next = ST_DONE;
            ST_DONE:   if (dl_match) state_next = ST_ACTIVE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: memory ownership during download and drain, completion once drained.
    always_comb begin
        ldr_aen  = (state_reg == ST_ACTIVE) || (state_reg == ST_FLUSH);
        ldr_done = (state_reg == ST_DONE);
    end

    // Byte packing: decide partial-word update and whether a word enters the FIFO.
    always_comb begin
        part_be_next   = part_be_reg;
        part_addr_next = part_addr_reg;
        part_data_next = part_data_reg;
        fifo_push      = 1'b0;
        push_addr      = part_addr_reg;
        push_data      = part_data_reg;
        push_be        = part_be_reg;
        ovf_set        = 1'b0;
        if (byte_cap) begin
            if (byte_oor) begin
                ovf_set = 1'b1;
            end else if ((part_be_reg == 2'b00) || (part_addr_reg != byte_waddr)) begin
                // A pending partial for another word goes out as-is.
                fifo_push      = (part_be_reg != 2'b00);
                part_be_next   = byte_be;
                part_addr_next = byte_waddr;
                part_data_next = byte_lane_data;
            end else if ((part_be_reg & byte_be) == 2'b00) begin
                fifo_push    = 1'b1;
                push_be      = 2'b11;
                push_data    = part_data_reg | byte_lane_data;
                part_be_next = 2'b00;
            end else begin
                // Same lane written twice: the later byte wins.
                part_data_next = byte_odd ? {part_data_reg[15:8], ioctl_dout}
                                          : {ioctl_dout, part_data_reg[7:0]};
            end
        end else if ((state_reg == ST_FLUSH) && (part_be_reg != 2'b00) && !fifo_full) begin
            fifo_push    = 1'b1;
            part_be_next = 2'b00;
        end
    end

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count_reg;
        case ({fifo_push, fifo_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Datapath registers: partial word, FIFO pointers, back-pressure and overflow flag.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            part_be_reg   <= 2'b00;
            part_addr_reg <= '0;
            part_data_reg <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            wait_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            part_be_reg   <= part_be_next;
            part_addr_reg <= part_addr_next;
            part_data_reg <= part_data_next;
            if (fifo_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg     <= count_next;
            // One slot is kept free for a byte already in flight when wait rises.
            wait_reg      <= (count_next >= CNT_W'(FIFO_DEPTH - 1));
            if (enter_active)  ovf_reg <= 1'b0;
            else if (ovf_set)  ovf_reg <= 1'b1;
        end
    end

    // FIFO storage write; contents need no reset because the count gates visibility.
    always_ff @(posedge clk_sys) begin
        if (fifo_push) begin
            fifo_addr_mem[wr_ptr_reg] <= push_addr;
            fifo_data_mem[wr_ptr_reg] <= push_data;
            fifo_be_mem[wr_ptr_reg]   <= push_be;
        end
    end

    assign ldr_wr     = !fifo_empty;
    assign ldr_addr   = fifo_empty ? '0 : fifo_addr_mem[rd_ptr_reg];
    assign ldr_wdat   = fifo_empty ? '0 : fifo_data_mem[rd_ptr_reg];
    assign ldr_be     = fifo_empty ? '0 : fifo_be_mem[rd_ptr_reg];
    assign ioctl_wait = wait_reg;
    assign ldr_ovf    = ovf_reg;

    a_no_push_full: assert property (@(posedge clk_sys) disable iff (reset)
                                     !(fifo_push && fifo_full));

endmodule

// File: tb/tb_x68k_ldr_ctrl.sv
// Directed testbench for x68k_ldr_ctrl: each task drives one scenario and
// checks outputs against hand-computed words.
module tb_x68k_ldr_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        ldr_aen;
    logic [19:0] ldr_addr;
    logic [15:0] ldr_wdat;
    logic [1:0]  ldr_be;
    logic        ldr_wr;
    logic        ldr_ack;
    logic        ldr_done;
    logic        ldr_ovf;

    int n_vec = 0;
    int n_err = 0;

    logic [19:0] mon_addr [$];
    logic [15:0] mon_dat  [$];
    logic [1:0]  mon_be   [$];
    bit          wr_seen;

    always #5 clk_sys = ~clk_sys;

    x68k_ldr_ctrl #(.ADDR_W(20), .FIFO_DEPTH(4), .LDR_INDEX(8'd0)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .ldr_aen        (ldr_aen),
        .ldr_addr       (ldr_addr),
        .ldr_wdat       (ldr_wdat),
        .ldr_be         (ldr_be),
        .ldr_wr         (ldr_wr),
        .ldr_ack        (ldr_ack),
        .ldr_done       (ldr_done),
        .ldr_ovf        (ldr_ovf)
    );

    // Record every accepted loader write (ldr_wr & ldr_ack seen mid-cycle).
    always @(negedge clk_sys) begin
        if (!reset && ldr_wr) begin
            wr_seen = 1'b1;
            if (ldr_ack) begin
                mon_addr.push_back(ldr_addr);
                mon_dat.push_back(ldr_wdat);
                mon_be.push_back(ldr_be);
                $display("word addr=%05h data=%04h be=%b", ldr_addr, ldr_wdat, ldr_be);
            end
        end
    end

    task automatic clear_mon();
        mon_addr.delete();
        mon_dat.delete();
        mon_be.delete();
        wr_seen = 1'b0;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        @(posedge clk_sys); #1;
    endtask

    task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
        int n = 0;
        while (ioctl_wait && n < 50) begin
            @(posedge clk_sys); #1;
            n++;
        end
        if (ioctl_wait) begin
            n_vec++; n_err++;
            $display("FAIL wait_timeout: ioctl_wait still %b after %0d cycles, need 0", ioctl_wait, n);
        end
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(posedge clk_sys); #1;
        ioctl_wr   = 1'b0;
    endtask

    // Drop download and wait (bounded) for ldr_done; callers check the result.
    task automatic finish_dl(input int max_cyc);
        ioctl_download = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk_sys);
            @(negedge clk_sys);
            if (ldr_done) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk_sys);
        n_vec++;
        if ({ldr_wr, ldr_aen, ldr_done, ldr_ovf, ioctl_wait, ldr_be} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b need 0000000",
                     {ldr_wr, ldr_aen, ldr_done, ldr_ovf, ioctl_wait, ldr_be});
        end
        n_vec++;
        if ({ldr_addr, ldr_wdat} !== 36'h0) begin
            n_err++;
            $display("FAIL reset_data: got addr=%h data=%h need 0", ldr_addr, ldr_wdat);
        end
        @(posedge clk_sys); #1;
        reset = 1'b0;
        @(posedge clk_sys); #1;
    endtask

    task automatic test_basic();
        logic [19:0] ea [2] = '{20'h00000, 20'h00002};
        logic [15:0] ed [2] = '{16'h1122, 16'h3344};
        clear_mon();
        ldr_ack = 1'b1;
        start_dl(8'd0);
        n_vec++;
        if (ldr_aen !== 1'b1) begin
            n_err++; $display("FAIL basic_aen: got %b need 1", ldr_aen);
        end
        write_byte(25'h0, 8'h11);
        write_byte(25'h1, 8'h22);
        n_vec++;
        if (ldr_wr !== 1'b1 || ldr_wdat !== 16'h1122) begin
            n_err++;
            $display("FAIL basic_latency: got wr=%b data=%h need wr=1 data=1122", ldr_wr, ldr_wdat);
        end
        write_byte(25'h2, 8'h33);
        write_byte(25'h3, 8'h44);
        finish_dl(3);
        n_vec++;
        if (ldr_done !== 1'b1 || ldr_aen !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done: got done=%b aen=%b need done=1 aen=0", ldr_done, ldr_aen);
        end
        n_vec++;
        if (mon_addr.size() != 2) begin
            n_err++; $display("FAIL basic_count: got %0d words need 2", mon_addr.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (mon_addr[k] !== ea[k] || mon_dat[k] !== ed[k] || mon_be[k] !== 2'b11) begin
                    n_err++;
                    $display("FAIL basic_word%0d: got %h/%h/%b need %h/%h/11",
                             k, mon_addr[k], mon_dat[k], mon_be[k], ea[k], ed[k]);
                end
            end
        end
    endtask

    task automatic test_odd_length();
        logic [19:0] ea [2] = '{20'h00100, 20'h00102};
        logic [15:0] ed [2] = '{16'hAABB, 16'hCC00};
        logic [1:0]  eb [2] = '{2'b11, 2'b10};
        clear_mon();
        ldr_ack = 1'b1;
        start_dl(8'd0);
        write_byte(25'h100, 8'hAA);
        write_byte(25'h101, 8'hBB);
        write_byte(25'h102, 8'hCC);
        repeat (3) begin @(posedge clk_sys); #1; end
        n_vec++;
        if (mon_addr.size() != 1 || ldr_wr !== 1'b0) begin
            n_err++;
            $display("FAIL odd_hold_partial: got %0d words wr=%b need 1 word wr=0",
                     mon_addr.size(), ldr_wr);
        end
        finish_dl(5);
        n_vec++;
        if (ldr_done !== 1'b1) begin
            n_err++; $display("FAIL odd_done: got %b need 1", ldr_done);
        end
        n_vec++;
        if (mon_addr.size() != 2) begin
            n_err++; $display("FAIL odd_count: got %0d words need 2", mon_addr.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (mon_addr[k] !== ea[k] || mon_dat[k] !== ed[k] || mon_be[k] !== eb[k]) begin
                    n_err++;
                    $display("FAIL odd_word%0d: got %h/%h/%b need %h/%h/%b",
                             k, mon_addr[k], mon_dat[k], mon_be[k], ea[k], ed[k], eb[k]);
                end
            end
        end
    endtask

    task automatic test_ignored_index();
        clear_mon();
        ldr_ack = 1'b1;
        start_dl(8'd2);
        write_byte(25'h0, 8'h55);
        write_byte(25'h1, 8'h66);
        repeat (2) begin @(posedge clk_sys); #1; end
        n_vec++;
        if (ldr_aen !== 1'b0 || ldr_done !== 1'b1) begin
            n_err++;
            $display("FAIL ignored_flags: got aen=%b done=%b need aen=0 done=1", ldr_aen, ldr_done);
        end
        ioctl_download = 1'b0;
        repeat (3) begin @(posedge clk_sys); #1; end
        n_vec++;
        if (wr_seen !== 1'b0 || ldr_done !== 1'b1 || ldr_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL ignored_after: got wr_seen=%b done=%b ovf=%b need 0/1/0",
                     wr_seen, ldr_done, ldr_ovf);
        end
    endtask

    task automatic test_overflow();
        clear_mon();
        ldr_ack = 1'b1;
        start_dl(8'd0);
        n_vec++;
        if (ldr_done !== 1'b0 || ldr_aen !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_restart: got done=%b aen=%b need done=0 aen=1", ldr_done, ldr_aen);
        end
        write_byte(25'h100000, 8'h99);
        n_vec++;
        if (ldr_ovf !== 1'b1) begin
            n_err++; $display("FAIL ovf_set: got %b need 1", ldr_ovf);
        end
        finish_dl(5);
        n_vec++;
        if (ldr_done !== 1'b1 || ldr_ovf !== 1'b1 || wr_seen !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_end: got done=%b ovf=%b wr_seen=%b need 1/1/0",
                     ldr_done, ldr_ovf, wr_seen);
        end
    endtask

    task automatic test_discontiguous();
        clear_mon();
        ldr_ack = 1'b1;
        start_dl(8'd0);
        n_vec++;
        if (ldr_ovf !== 1'b0) begin
            n_err++; $display("FAIL disc_ovf_clear: got %b need 0", ldr_ovf);
        end
        write_byte(25'h5, 8'h77);
        n_vec++;
        if (ldr_wr !== 1'b0) begin
            n_err++; $display("FAIL disc_no_early: got wr=%b need 0", ldr_wr);
        end
        write_byte(25'h8, 8'h88);
        n_vec++;
        if (ldr_wr !== 1'b1 || ldr_addr !== 20'h00004 || ldr_wdat !== 16'h0077 || ldr_be !== 2'b01) begin
            n_err++;
            $display("FAIL disc_push: got wr=%b %h/%h/%b need 1 00004/0077/01",
                     ldr_wr, ldr_addr, ldr_wdat, ldr_be);
        end
        finish_dl(5);
        n_vec++;
        if (mon_addr.size() != 2) begin
            n_err++; $display("FAIL disc_count: got %0d words need 2", mon_addr.size());
        end else begin
            n_vec++;
            if (mon_addr[1] !== 20'h00008 || mon_dat[1] !== 16'h8800 || mon_be[1] !== 2'b10) begin
                n_err++;
                $display("FAIL disc_tail: got %h/%h/%b need 00008/8800/10",
                         mon_addr[1], mon_dat[1], mon_be[1]);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [19:0] wa;
        logic [15:0] wd;
        clear_mon();
        ldr_ack = 1'b0;
        start_dl(8'd0);
        for (int i = 0; i < 4; i++) write_byte(25'h200 + 25'(i), 8'h10 + 8'(i));
        n_vec++;
        if (ioctl_wait !== 1'b0) begin
            n_err++; $display("FAIL bp_wait_low: got %b need 0 at 2 words", ioctl_wait);
        end
        for (int i = 4; i < 6; i++) write_byte(25'h200 + 25'(i), 8'h10 + 8'(i));
        n_vec++;
        if (ioctl_wait !== 1'b1 || ldr_wr !== 1'b1) begin
            n_err++;
            $display("FAIL bp_wait_high: got wait=%b wr=%b need 1/1 at 3 words", ioctl_wait, ldr_wr);
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk_sys); #1;
            n_vec++;
            if (ldr_addr !== 20'h00200 || ldr_wdat !== 16'h1011 || ldr_be !== 2'b11 || ioctl_wait !== 1'b1) begin
                n_err++;
                $display("FAIL bp_stable%0d: got %h/%h/%b wait=%b need 00200/1011/11 wait=1",
                         c, ldr_addr, ldr_wdat, ldr_be, ioctl_wait);
            end
        end
        ldr_ack = 1'b1;
        for (int i = 6; i < 12; i++) write_byte(25'h200 + 25'(i), 8'h10 + 8'(i));
        finish_dl(20);
        n_vec++;
        if (ldr_done !== 1'b1) begin
            n_err++; $display("FAIL bp_done: got %b need 1", ldr_done);
        end
        n_vec++;
        if (mon_addr.size() != 6) begin
            n_err++; $display("FAIL bp_count: got %0d words need 6", mon_addr.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                wa = 20'h00200 + 20'(2 * k);
                wd = {8'h10 + 8'(2 * k), 8'h11 + 8'(2 * k)};
                n_vec++;
                if (mon_addr[k] !== wa || mon_dat[k] !== wd || mon_be[k] !== 2'b11) begin
                    n_err++;
                    $display("FAIL bp_word%0d: got %h/%h/%b need %h/%h/11",
                             k, mon_addr[k], mon_dat[k], mon_be[k], wa, wd);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        ldr_ack = 1'b0;
        start_dl(8'd0);
        for (int i = 0; i < 4; i++) write_byte(25'h300 + 25'(i), 8'hE0 + 8'(i));
        n_vec++;
        if (ldr_wr !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_queued: got wr=%b need 1", ldr_wr);
        end
        @(negedge clk_sys);
        reset = 1'b1;
        #1;
        n_vec++;
        if (ldr_wr !== 1'b0 || ldr_aen !== 1'b0 || ldr_done !== 1'b0 || ioctl_wait !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_async: got wr=%b aen=%b done=%b wait=%b need all 0",
                     ldr_wr, ldr_aen, ldr_done, ioctl_wait);
        end
        ioctl_download = 1'b0;
        @(posedge clk_sys); #1;
        reset   = 1'b0;
        ldr_ack = 1'b1;
        repeat (2) begin @(posedge clk_sys); #1; end
        n_vec++;
        if (ldr_wr !== 1'b0 || ldr_aen !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_idle: got wr=%b aen=%b need 0/0", ldr_wr, ldr_aen);
        end
        clear_mon();
        start_dl(8'd0);
        write_byte(25'h10, 8'h5A);
        write_byte(25'h11, 8'hA5);
        finish_dl(5);
        n_vec++;
        if (ldr_done !== 1'b1 || mon_addr.size() != 1) begin
            n_err++;
            $display("FAIL rst_mid_redo: got done=%b words=%0d need 1/1", ldr_done, mon_addr.size());
        end else begin
            n_vec++;
            if (mon_addr[0] !== 20'h00010 || mon_dat[0] !== 16'h5AA5 || mon_be[0] !== 2'b11) begin
                n_err++;
                $display("FAIL rst_mid_word: got %h/%h/%b need 00010/5AA5/11",
                         mon_addr[0], mon_dat[0], mon_be[0]);
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        ldr_ack        = 1'b0;
        wr_seen        = 1'b0;
        test_reset();
        test_basic();
        test_odd_length();
        test_ignored_index();
        test_overflow();
        test_discontiguous();
        test_back_pressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
